bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Two-digit synchronous BCD up/down counter that generates the 4-bit BCD codes fed to the BCD-to-decimal decoder stage.
- Each digit is presented MSB-first as a 4-bit nibble. Bit 3 drives decoder input a, bit 0 drives decoder input d.
- Supports parallel load with digit validation, a programmable tick prescaler and a wrap/carry pulse for cascading.

Parameters:
- TICK_DIV, 1: number of enabled clock cycles per count step; legal range 1..255.
- DIV_W, 8: width of the internal prescaler counter; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; the prescaler advances only while en=1.
- up  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous parallel load request.
- load_tens  in  4  BCD tens value used on load.
- load_ones  in  4  BCD ones value used on load.
- tens  out  4  current tens digit; bit3=a … bit0=d.
- ones  out  4  current ones digit; bit3=a … bit0=d.
- carry  out  1  one-cycle pulse on wrap (99->00 when up, 00->99 when down).
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset and clocking:
  - One clock domain. rst is asynchronous and active-high.
  - While rst=1: tens=0, ones=0, carry=0, load_err=0, prescaler=0. This holds regardless of clk.
  - Release of rst takes effect at the next rising edge of clk; no edge is lost.
- Outputs: all are registered. Values change only on the rising edge of clk at which the triggering condition is sampled, so visible latency is 1 cycle.
- Priority per edge: rst > load > count step > hold.
- Load:
  - Sampled at load=1. If load_tens<=9 and load_ones<=9, the digits take those values, the prescaler clears to 0, and carry=0.
  - If either digit is >9: the digits and prescaler are unchanged, load_err=1 for exactly that cycle, and no count step occurs on that edge.
  - While load=1 is held across several edges, each edge re-evaluates the load.
- Prescaler:
  - Updates only when en=1 and load=0.
  - If prescaler==TICK_DIV-1, it returns to 0 and a step fires; otherwise it increments.
  - With en=0 the prescaler holds its value and is not cleared.
  - TICK_DIV=1 produces a step on every enabled cycle.
- Up step:
  - ones==9: ones becomes 0 and tens increments. tens==9 with ones==9 gives 00 and carry=1.
  - Otherwise ones increments.
- Down step:
  - ones==0: ones becomes 9 and tens decrements. tens==0 with ones==0 gives 99 and carry=1.
  - Otherwise ones decrements.
- Direction changes: up may change between steps. The direction used is the value sampled on the stepping edge.
- carry:
  - High only for the cycle after the wrapping edge.
  - Never asserted by a load.
  - Deasserted on every other edge.
- Digit range: the counter never produces a nibble >9 in either digit. Codes 1010–1111 are unreachable.
- Reset mid-prescale: the prescaler is cleared, so the first step after reset takes a full TICK_DIV enabled cycles.

Test Plan:
- Reset and first count: assert rst mid-cycle with the counter at 57 and TICK_DIV=1. Outputs go to 00 immediately without a clk edge. Release rst, hold en=1, up=1. After 10 edges the count reads 10 (tens=0001, ones=0000).
- Up wrap: load 98, then en=1, up=1.
  - Edge 1 gives 99, carry=0.
  - Edge 2 gives 00 with carry=1 for exactly one cycle.
  - Edge 3 gives 01, carry=0.
- Down wrap and digit borrow: load 10, then en=1, up=0. Count sequence is 09, 08 … 00, then 99 with carry=1. tens decrements exactly on the 10->09 edge.
- Invalid load: from 42, set load=1 with load_tens=3, load_ones=12 (1100). Count stays 42, load_err=1 for one cycle, and carry=0.
- Prescaler, using TICK_DIV=4:
  - With en=1 and up=1 from 00, steps occur on edges 4, 8 and 12, giving 01, 02, 03.
  - Drop en for 5 cycles after edge 6. The next step then occurs 2 enabled edges after en returns.
  - A load at any point restarts the 4-cycle count.
- Load vs count collision: at 55 with en=1 and the prescaler at TICK_DIV-1, assert load with 20. Result is 20 (no step applied), carry=0, and the prescaler is 0.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter with validated parallel load, tick prescaler and wrap pulse.
// Registered outputs, 1-cycle latency; no backpressure (load > count step > hold).
module bcd_updown_counter #(
    parameter int TICK_DIV = 1,
    parameter int DIV_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry,
    output logic       load_err
);

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] presc;
    logic [3:0]       step_tens;
    logic [3:0]       step_ones;
    logic             step_wrap;
    logic             load_ok;

    assign load_ok = (load_tens <= 4'd9) && (load_ones <= 4'd9);

    // Next digit pair if a step fires this edge, in the sampled direction.
    always_comb begin
        step_tens = tens;
        step_ones = ones;
        step_wrap = 1'b0;
        if (up) begin
            if (ones == 4'd9) begin
                step_ones = 4'd0;
                if (tens == 4'd9) begin
                    step_tens = 4'd0;
                    step_wrap = 1'b1;
                end else begin
                    step_tens = tens + 4'd1;
                end
            end else begin
                step_ones = ones + 4'd1;
            end
        end else begin
            if (ones == 4'd0) begin
                step_ones = 4'd9;
                if (tens == 4'd0) begin
                    step_tens = 4'd9;
                    step_wrap = 1'b1;
                end else begin
                    step_tens = tens - 4'd1;
                end
            end else begin
                step_ones = ones - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens     <= 4'd0;
            ones     <= 4'd0;
            presc    <= '0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                // A rejected load still consumes the edge: no step, prescaler untouched.
                if (load_ok) begin
                    tens  <= load_tens;
                    ones  <= load_ones;
                    presc <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (presc == TICK_LAST) begin
                    presc <= '0;
                    tens  <= step_tens;
                    ones  <= step_ones;
                    carry <= step_wrap;
                end else begin
                    presc <= presc + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: TICK_DIV=1 and TICK_DIV=4 instances on shared stimulus,
// checked against an integer-valued reference model (value 0..99 plus a tick count).
module tb_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic [3:0] tens1, ones1, tens4, ones4;
    logic       carry1, carry4, err1, err4;

    always #5 clk = ~clk;

    bcd_updown_counter #(.TICK_DIV(1), .DIV_W(8)) u_div1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens1), .ones(ones1), .carry(carry1), .load_err(err1)
    );

    bcd_updown_counter #(.TICK_DIV(4), .DIV_W(3)) u_div4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens4), .ones(ones4), .carry(carry4), .load_err(err4)
    );

    int vectors = 0;
    int miscompares = 0;

    int m_val[2];
    int m_tick[2];
    int m_carry[2];
    int m_err[2];
    int divs[2] = '{1, 4};

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_tick[k] = 0; m_carry[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_edge();
        int lt, lo;
        lt = int'(load_tens);
        lo = int'(load_ones);
        for (int k = 0; k < 2; k++) begin
            m_carry[k] = 0;
            m_err[k]   = 0;
            if (load) begin
                if (lt <= 9 && lo <= 9) begin
                    m_val[k]  = lt * 10 + lo;
                    m_tick[k] = 0;
                end else begin
                    m_err[k] = 1;
                end
            end else if (en) begin
                m_tick[k] = m_tick[k] + 1;
                if (m_tick[k] == divs[k]) begin
                    m_tick[k] = 0;
                    if (up) begin
                        m_carry[k] = (m_val[k] == 99) ? 1 : 0;
                        m_val[k]   = (m_val[k] + 1) % 100;
                    end else begin
                        m_carry[k] = (m_val[k] == 0) ? 1 : 0;
                        m_val[k]   = (m_val[k] + 99) % 100;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("d1_tens",  int'(tens1),  m_val[0] / 10);
        chk("d1_ones",  int'(ones1),  m_val[0] % 10);
        chk("d1_carry", int'(carry1), m_carry[0]);
        chk("d1_err",   int'(err1),   m_err[0]);
        chk("d4_tens",  int'(tens4),  m_val[1] / 10);
        chk("d4_ones",  int'(ones4),  m_val[1] % 10);
        chk("d4_carry", int'(carry4), m_carry[1]);
        chk("d4_err",   int'(err4),   m_err[1]);
    endtask

    // Drive at the falling edge, model the rising edge, compare 1 time unit later.
    task automatic cyc(input bit e, input bit u, input bit l, input int lt, input int lo);
        @(negedge clk);
        en = e; up = u; load = l;
        load_tens = lt[3:0];
        load_ones = lo[3:0];
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1 check_all();
    endtask

    // Called just after a rising edge: assert reset mid-cycle, hold it over one edge, release mid-cycle.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_async_tens", int'(tens1), 0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        load_tens = 4'd0; load_ones = 4'd0;
        model_reset();
        @(posedge clk);
        #1 check_all();
        rst = 1'b0;

        // Reset mid-cycle from 57, then count up from 00.
        cyc(1'b0, 1'b1, 1'b1, 5, 7);
        chk("load57_ones", int'(ones1), 7);
        async_reset();
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("first10_tens", int'(tens1), 1);
        chk("first10_ones", int'(ones1), 0);

        // Up wrap.
        cyc(1'b0, 1'b1, 1'b1, 9, 8);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("upwrap_99_carry", int'(carry1), 0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("upwrap_00_ones", int'(ones1), 0);
        chk("upwrap_00_carry", int'(carry1), 1);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("upwrap_01_carry", int'(carry1), 0);

        // Down wrap with borrow.
        cyc(1'b0, 1'b0, 1'b1, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        chk("down_09_tens", int'(tens1), 0);
        chk("down_09_ones", int'(ones1), 9);
        repeat (9) cyc(1'b1, 1'b0, 1'b0, 0, 0);
        chk("down_00_carry", int'(carry1), 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        chk("down_99_tens", int'(tens1), 9);
        chk("down_99_carry", int'(carry1), 1);

        // Invalid load from 42 with en active: no step, error pulse.
        cyc(1'b0, 1'b1, 1'b1, 4, 2);
        cyc(1'b1, 1'b1, 1'b1, 3, 12);
        chk("badload_ones", int'(ones1), 2);
        chk("badload_err", int'(err1), 1);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        chk("badload_err_clr", int'(err1), 0);

        // Prescaler on the TICK_DIV=4 instance.
        cyc(1'b0, 1'b1, 1'b1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 0, 0);
            if (i == 3) chk("div4_e3", int'(ones4), 0);
            if (i == 4) chk("div4_e4", int'(ones4), 1);
            if (i == 12) chk("div4_e12", int'(ones4), 3);
        end
        cyc(1'b0, 1'b1, 1'b1, 0, 0);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        repeat (5) cyc(1'b0, 1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("div4_hold_1", int'(ones4), 1);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("div4_hold_2", int'(ones4), 2);
        cyc(1'b0, 1'b1, 1'b1, 0, 0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 3, 0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("div4_restart_30", int'(ones4), 0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("div4_restart_31", int'(ones4), 1);

        // Load colliding with a due step.
        cyc(1'b0, 1'b1, 1'b1, 5, 5);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 2, 0);
        chk("collide_tens", int'(tens4), 2);
        chk("collide_ones", int'(ones4), 0);
        chk("collide_carry", int'(carry4), 0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("collide_presc0", int'(ones4), 0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        chk("collide_step", int'(ones4), 1);

        // Randomized traffic, including invalid loads and occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 11)), int'($urandom_range(0, 11)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
